// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory, fetch-to-decode and redirect signals of the fetch stage.
interface fetch_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INSN_WIDTH = 32
);
    logic                  mem_req_valid;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_ready;
    logic                  mem_rsp_valid;
    logic [INSN_WIDTH-1:0] mem_rsp_data;
    logic                  f2d_valid;
    logic [ADDR_WIDTH-1:0] f2d_pc;
    logic [INSN_WIDTH-1:0] f2d_insn;
    logic                  f2d_accept;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    modport master (
        output mem_req_valid, mem_req_addr, f2d_valid, f2d_pc, f2d_insn,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, f2d_accept, redirect_valid, redirect_pc
    );
    modport slave (
        input  mem_req_valid, mem_req_addr, f2d_valid, f2d_pc, f2d_insn,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, f2d_accept, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues one instruction read at a time, hands packets to decode
// and drops responses made stale by an execute redirect.
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INSN_WIDTH = 32,
    parameter int                    INSN_BYTES = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic           clk,
    input logic           reset,
    fetch_stage_if.master bus
);
    typedef enum logic [2:0] {START, REQUEST, WAIT_RSP, DROP, HOLD} state_t;
    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pc_n, target, f2d_pc;
    logic [INSN_WIDTH-1:0] f2d_insn;
    logic                  f2d_valid, send, redirect, rsp;
    assign redirect = bus.redirect_valid;
    assign rsp      = bus.mem_rsp_valid;
    assign target   = bus.redirect_pc & ~ADDR_WIDTH'(INSN_BYTES - 1);
    always_comb begin
        state_n = state;
        send    = 1'b0;
        case (state)
            START:    state_n = REQUEST;
            REQUEST:  state_n = bus.mem_req_ready ? (redirect ? DROP : WAIT_RSP) : REQUEST;
            WAIT_RSP: begin
                send    = rsp && !redirect;
                state_n = rsp ? (redirect ? REQUEST : HOLD) : (redirect ? DROP : WAIT_RSP);
            end
            DROP:     state_n = rsp ? REQUEST : DROP;
            HOLD:     state_n = (redirect || bus.f2d_accept) ? REQUEST : HOLD;
            default:  state_n = START;
        endcase
        pc_n = redirect ? target : send ? pc + ADDR_WIDTH'(INSN_BYTES) : pc;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= START;
            pc        <= RESET_PC;
            f2d_valid <= 1'b0;
            f2d_pc    <= '0;
            f2d_insn  <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (send) begin
                f2d_valid <= 1'b1;
                f2d_pc    <= pc;
                f2d_insn  <= bus.mem_rsp_data;
            end else if (state == HOLD && state_n == REQUEST) begin
                f2d_valid <= 1'b0;
            end
        end
    end
    assign bus.mem_req_valid = (state == REQUEST);
    assign bus.mem_req_addr  = pc;
    assign bus.f2d_valid     = f2d_valid;
    assign bus.f2d_pc        = f2d_pc;
    assign bus.f2d_insn      = f2d_insn;
    // A response with nothing outstanding is a memory protocol violation.
    assert property (@(posedge clk) disable iff (reset)
        !(rsp && (state == START || state == REQUEST || state == HOLD)));
    assert property (@(posedge clk) disable iff (reset) !(send && f2d_valid));
endmodule
